mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin arbiter that shares one pipelined signed 11-bit × 8-bit multiplier core (19-bit result, no stall, no reset) among NREQ requesters. It accepts one operand pair per cycle, tracks the owner of every in-flight product with a tag pipeline matched to the core latency, and steers each product into that requester's response FIFO. Credit-based issue guarantees no FIFO overflow, because the core cannot be backpressured.

## Interface
- NREQ, 4: number of requesters (2..8).
- MUL_LAT, 8: clock edges from the core sampling operands to the product appearing on mul_result.
- FIFO_DEPTH, 4: entries per response FIFO; this is also the per-requester credit count (≥1).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  operand pair valid, one bit per requester.
- req_ready  out  NREQ  grant; a transfer occurs when req_valid[i] & req_ready[i].
- req_n1  in  NREQ*11  signed multiplicand, slice i = [11i+10:11i].
- req_n2  in  NREQ*8  signed multiplier, slice i = [8i+7:8i].
- rsp_valid  out  NREQ  response FIFO non-empty.
- rsp_ready  in  NREQ  pop response i.
- rsp_data  out  NREQ*19  FIFO head, slice i = [19i+18:19i].
- mul_n1  out  11  operand A to the core.
- mul_n2  out  8  operand B to the core.
- mul_result  in  19  product from the core.
- busy  out  1  any tag in flight or any FIFO non-empty.

## Operation
- Eligibility: eligible[i] = req_valid[i] & (credit[i] != 0).
- Arbitration: round-robin from pointer ptr. The first eligible index at or after ptr (mod NREQ) is granted. At most one grant per cycle. req_ready is combinational from req_valid and credit state. Requesters must not make req_valid depend on req_ready.
- ptr update: on a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Issue: mul_n1/mul_n2 = granted requester's operands, combinational mux. With no grant, both are driven to 0.
- Tag pipeline: MUL_LAT stages of {vld, id[clog2(NREQ)-1:0]}. Stage 0 loads {grant_any, grant_id} every edge.
- Retire: when the last tag stage has vld=1, mul_result is written into FIFO[id] at the next edge. Products are written as delivered by the core. Sign and zero handling (including a +0 result) belong to the core.
- Credit per requester: ranges 0..FIFO_DEPTH, reset value FIFO_DEPTH. Issue decrements it; a pop (rsp_valid & rsp_ready) increments it. Issue and pop in the same cycle leave it unchanged.
- FIFO: show-ahead, with no write-to-read bypass. A write into an empty FIFO shows rsp_valid on the following cycle. Overflow is impossible by construction; an overflow is an assertion failure.
- Popping an empty FIFO is ignored.
- Reset, including mid-operation: all tag vld=0, FIFOs empty, credits = FIFO_DEPTH, ptr=0. Products still inside the core are discarded, because no valid tag accompanies them.

## Timing
- Reset values: req_ready=0 (while req_valid=0), rsp_valid=0, rsp_data=0, mul_n1=0, mul_n2=0, busy=0.
- Accept at edge k, then the product is written into the FIFO at edge k+MUL_LAT. rsp_valid is high in the cycle after edge k+MUL_LAT.
- Throughput: 1 op/cycle aggregate. A single requester that never pops stalls after FIFO_DEPTH issues. Other requesters are unaffected.
- Back-to-back grants to one requester are allowed while credit remains. Round-robin still rotates among the requesters that are eligible.

## Structure
- Package mult_arb_pkg:
  - N1_W=11, N2_W=8, RES_W=19.
  - Function id_w(NREQ).
  - Typedef tag_t {vld, id}.
- Sub-module mult_rsp_fifo (parameter DEPTH, width RES_W), instantiated NREQ times.
  - Contains the pointers and count.
  - The credit counter lives in the arbiter.
- The multiplier core sits outside this block. It is connected by the top level through the mul_* ports.

## Test plan
- Single op: requester 0 sends n1=3, n2=-5 → rsp_data[0]=19'h7FFF1 (-15), rsp_valid[0] rises exactly MUL_LAT cycles after the accept edge.
- Extremes: n1=-1024, n2=-128 → 19'h20000. A zero operand (n1=0, n2=-7) → 19'h00000.
- Fairness: all four requesters hold req_valid with rsp_ready=1 → grants cycle 0,1,2,3,0,… and every result lands in its own FIFO in issue order.
- Credit stall: requester 2 streams with rsp_ready[2]=0 → exactly FIFO_DEPTH accepts, then req_ready[2]=0 while the other requesters continue. One pop re-enables exactly one accept.
- Simultaneous issue and pop on a requester with credit 1 → credit stays 1, and no ready drop occurs.
- Reset mid-flight: assert rst_n=0 with 5 tags in flight → all outputs return to reset values. After release, no stale rsp_valid appears and credits are full.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// Shared widths, tag record and helpers for the shared-multiplier arbiter.
package mult_arb_pkg;

  localparam int N1_W     = 11;  // signed multiplicand width
  localparam int N2_W     = 8;   // signed multiplier width
  localparam int RES_W    = 19;  // product width
  localparam int ID_MAX_W = 3;   // requester id width for the largest supported NREQ (8)

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int nreq);
    if (nreq <= 2) begin
      return 1;
    end else begin
      return $clog2(nreq);
    end
  endfunction

  // One stage of the owner-tracking pipeline that runs beside the core.
  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester-side request/response bus of the shared-multiplier arbiter.
interface mult_share_arb_if #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]                       req_valid;
  logic [NREQ-1:0]                       req_ready;
  logic [NREQ*mult_arb_pkg::N1_W-1:0]    req_n1;
  logic [NREQ*mult_arb_pkg::N2_W-1:0]    req_n2;
  logic [NREQ-1:0]                       rsp_valid;
  logic [NREQ-1:0]                       rsp_ready;
  logic [NREQ*mult_arb_pkg::RES_W-1:0]   rsp_data;

  // Requester side: issues operand pairs and pops products.
  modport master (
    output req_valid, req_n1, req_n2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_n1, req_n2, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mult_rsp_fifo.sv
// Show-ahead response FIFO for one requester. The head is visible only once
// an entry has been registered, so there is no write-to-read bypass.
module mult_rsp_fifo
  import mult_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = RES_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_s;
  logic          empty_s;
  logic          wr_ok_s;
  logic          rd_ok_s;

  // Pointer advance that also works for non-power-of-two depths.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Status flags, qualified enables and masked head output.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == {CW{1'b0}});
    wr_ok_s  = wr_en & ~full_s;
    rd_ok_s  = rd_en & ~empty_s;
    rd_valid = ~empty_s;
    if (empty_s) begin
      rd_data = {W{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  mult_rsp_fifo_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .full  (full_s)
  );

endmodule

// File: rtl/mult_rsp_fifo_chk.sv
// Property checker for a response FIFO: a write must never hit a full FIFO,
// because credits are supposed to make that impossible.
module mult_rsp_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic wr_en,
  input logic full
);

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one external pipelined multiplier among NREQ
// requesters. A tag pipeline of the core's latency records who owns each
// product; credits sized to the response FIFOs stop issue before any FIFO
// could overflow, since the core itself cannot be stalled.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int MUL_LAT    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_share_arb_if.slave  bus,
  output logic [N1_W-1:0]  mul_n1,
  output logic [N2_W-1:0]  mul_n2,
  input  logic [RES_W-1:0] mul_result,
  output logic             busy
);

  localparam int IDW = id_w(NREQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [NREQ-1:0]  eligible_s;
  logic [NREQ-1:0]  grant_s;
  logic [NREQ-1:0]  wr_en_s;
  logic [NREQ-1:0]  pop_s;
  logic [NREQ-1:0]  rsp_valid_s;
  logic [RES_W-1:0] rsp_data_s [NREQ];
  logic [CW-1:0]    credit_r [NREQ];
  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_id_s;
  logic             grant_any_s;
  tag_t             tag_r [MUL_LAT];
  tag_t             tag_in_s;
  logic             tags_busy_s;

  // A requester may be granted only while it still has a free FIFO slot reserved.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible_s[i] = bus.req_valid[i] & (credit_r[i] != {CW{1'b0}});
    end
  end

  // Round-robin pick: first eligible index at or after ptr, wrapping.
  always_comb begin
    int idx;
    grant_any_s = 1'b0;
    grant_id_s  = {IDW{1'b0}};
    idx         = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_r) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!grant_any_s && eligible_s[idx]) begin
        grant_any_s = 1'b1;
        grant_id_s  = IDW'(idx);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Grant vector, operand mux (zero when idle) and the tag entering the pipe.
  always_comb begin
    if (grant_any_s) begin
      grant_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_s;
      mul_n1  = bus.req_n1[int'(grant_id_s)*N1_W +: N1_W];
      mul_n2  = bus.req_n2[int'(grant_id_s)*N2_W +: N2_W];
    end else begin
      grant_s = {NREQ{1'b0}};
      mul_n1  = {N1_W{1'b0}};
      mul_n2  = {N2_W{1'b0}};
    end
    bus.req_ready = grant_s;
    tag_in_s.vld  = grant_any_s;
    tag_in_s.id   = ID_MAX_W'(grant_id_s);
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IDW{1'b0}};
    end else if (grant_any_s) begin
      if (grant_id_s == IDW'(NREQ - 1)) begin
        ptr_r <= {IDW{1'b0}};
      end else begin
        ptr_r <= grant_id_s + {{(IDW-1){1'b0}}, 1'b1};
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Owner tags travel alongside the operands through the core's latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tag_r[s] <= '{vld: 1'b0, id: {ID_MAX_W{1'b0}}};
      end
    end else begin
      tag_r[0] <= tag_in_s;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

  // Retire steering, pops, and the in-flight indicator.
  always_comb begin
    tags_busy_s = 1'b0;
    for (int s = 0; s < MUL_LAT; s++) begin
      tags_busy_s = tags_busy_s | tag_r[s].vld;
    end
    for (int i = 0; i < NREQ; i++) begin
      wr_en_s[i] = tag_r[MUL_LAT-1].vld && (tag_r[MUL_LAT-1].id == ID_MAX_W'(i));
    end
    pop_s         = rsp_valid_s & bus.rsp_ready;
    bus.rsp_valid = rsp_valid_s;
    for (int i = 0; i < NREQ; i++) begin
      bus.rsp_data[i*RES_W +: RES_W] = rsp_data_s[i];
    end
    busy = tags_busy_s | (|rsp_valid_s);
  end

  // Credits: issue takes one, a pop returns one, both together cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        credit_r[i] <= CW'(FIFO_DEPTH);
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({grant_s[i], pop_s[i]})
          2'b10:   credit_r[i] <= credit_r[i] - {{(CW-1){1'b0}}, 1'b1};
          2'b01:   credit_r[i] <= credit_r[i] + {{(CW-1){1'b0}}, 1'b1};
          default: credit_r[i] <= credit_r[i];
        endcase
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    mult_rsp_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (RES_W)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en_s[g]),
      .wr_data  (mul_result),
      .rd_en    (bus.rsp_ready[g]),
      .rd_valid (rsp_valid_s[g]),
      .rd_data  (rsp_data_s[g])
    );
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb with a behavioural
// pipelined multiplier standing in for the external core.
module tb_mult_share_arb;

  localparam int NREQ       = 4;
  localparam int MUL_LAT    = 8;
  localparam int FIFO_DEPTH = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] mul_n1;
  logic [7:0]  mul_n2;
  logic [18:0] mul_result;
  logic        busy;

  logic signed [18:0] a_s, b_s, prod_s;
  logic [18:0]        core_pipe [MUL_LAT];

  int checks = 0;
  int errors = 0;

  mult_share_arb_if #(.NREQ(NREQ)) bus ();

  mult_share_arb #(
    .NREQ       (NREQ),
    .MUL_LAT    (MUL_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mul_n1     (mul_n1),
    .mul_n2     (mul_n2),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Core model: signed product, MUL_LAT register stages, no reset.
  assign a_s        = {{8{mul_n1[10]}}, mul_n1};
  assign b_s        = {{11{mul_n2[7]}}, mul_n2};
  assign prod_s     = a_s * b_s;
  assign mul_result = core_pipe[MUL_LAT-1];

  always_ff @(posedge clk) begin
    core_pipe[0] <= prod_s;
    for (int s = 1; s < MUL_LAT; s++) begin
      core_pipe[s] <= core_pipe[s-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [18:0] rsp_slice(input int i);
    return bus.rsp_data[19*i +: 19];
  endfunction

  initial begin
    logic [18:0] exp19;
    bus.req_valid = 4'b0000;
    bus.req_n1    = 44'd0;
    bus.req_n2    = 32'd0;
    bus.rsp_ready = 4'b0000;
    #12;
    // Reset state
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    chk("rst_rsp_data", bus.rsp_data, 76'd0);
    chk("rst_mul_n1", mul_n1, 11'd0);
    chk("rst_mul_n2", mul_n2, 8'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single op: 3 * -5 = -15
    bus.req_n1[10:0] = 11'd3;
    bus.req_n2[7:0]  = 8'hFB;
    bus.req_valid    = 4'b0001;
    #1;
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_mul_n1", mul_n1, 11'd3);
    chk("single_mul_n2", mul_n2, 8'hFB);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("single_busy", busy, 1'b1);
    repeat (MUL_LAT - 1) tick();
    chk("single_early", bus.rsp_valid, 4'b0000);
    tick();
    chk("single_valid", bus.rsp_valid, 4'b0001);
    chk("single_data", rsp_slice(0), 19'h7FFF1);
    bus.rsp_ready = 4'b0001;
    tick();
    bus.rsp_ready = 4'b0000;
    #1;
    chk("single_popped", bus.rsp_valid, 4'b0000);
    chk("single_idle", busy, 1'b0);

    // Extremes on requester 1, zero operand on requester 3
    bus.req_n1[21:11] = 11'h400;
    bus.req_n2[15:8]  = 8'h80;
    bus.req_n1[43:33] = 11'd0;
    bus.req_n2[31:24] = 8'hF9;
    bus.req_valid     = 4'b1010;
    #1;
    chk("ext_ready1", bus.req_ready, 4'b0010);
    chk("ext_mul_n1", mul_n1, 11'h400);
    chk("ext_mul_n2", mul_n2, 8'h80);
    tick();
    bus.req_valid = 4'b1000;
    #1;
    chk("ext_ready3", bus.req_ready, 4'b1000);
    chk("ext_zero_n2", mul_n2, 8'hF9);
    tick();
    bus.req_valid = 4'b0000;
    repeat (MUL_LAT - 1) tick();
    chk("ext_valid1", bus.rsp_valid, 4'b0010);
    chk("ext_data1", rsp_slice(1), 19'h20000);
    tick();
    chk("ext_valid3", bus.rsp_valid, 4'b1010);
    chk("ext_data3", rsp_slice(3), 19'h00000);
    bus.rsp_ready = 4'b1010;
    tick();
    bus.rsp_ready = 4'b0000;
    #1;
    chk("ext_popped", bus.rsp_valid, 4'b0000);

    // Fairness: all requesters valid, grants rotate 0,1,2,3,...
    bus.rsp_ready = 4'b1111;
    bus.req_n2    = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      bus.req_n1 = {4{11'(c + 1)}};
      #1;
      chk("fair_grant", bus.req_ready, 4'b0001 << (c % 4));
      chk("fair_mul_n1", mul_n1, 11'(c + 1));
      tick();
    end
    bus.req_valid = 4'b0000;
    tick();
    for (int j = 0; j < 8; j++) begin
      exp19 = 19'((j + 1) * ((j % 4) + 1));
      chk("fair_rsp_valid", bus.rsp_valid, 4'b0001 << (j % 4));
      chk("fair_rsp_data", rsp_slice(j % 4), exp19);
      tick();
    end
    chk("fair_drained", bus.rsp_valid, 4'b0000);

    // Credit stall on requester 2
    bus.rsp_ready     = 4'b1011;
    bus.req_n1[32:22] = 11'd100;
    bus.req_n2[23:16] = 8'hFE;
    bus.req_valid     = 4'b0100;
    for (int c = 0; c < FIFO_DEPTH; c++) begin
      #1;
      chk("stall_accept", bus.req_ready, 4'b0100);
      tick();
    end
    #1;
    chk("stall_ready", bus.req_ready, 4'b0000);
    bus.req_n1[21:11] = 11'd7;
    bus.req_n2[15:8]  = 8'd2;
    bus.req_valid     = 4'b0110;
    #1;
    chk("stall_other", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b0100;
    repeat (MUL_LAT - 1) tick();
    chk("stall_still", bus.req_ready, 4'b0000);
    chk("stall_full", bus.rsp_valid[2], 1'b1);
    chk("stall_data", rsp_slice(2), 19'h7FF38);
    bus.rsp_ready = 4'b1111;
    tick();
    bus.rsp_ready = 4'b1011;
    #1;
    chk("stall_one_pop", bus.req_ready, 4'b0100);
    tick();
    #1;
    chk("stall_one_only", bus.req_ready, 4'b0000);

    // Simultaneous issue and pop with credit 1
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 4'b1111;
    tick();
    bus.req_valid = 4'b0100;
    #1;
    chk("sim_ready0", bus.req_ready, 4'b0100);
    tick();
    #1;
    chk("sim_ready1", bus.req_ready, 4'b0100);
    tick();
    #1;
    chk("sim_ready2", bus.req_ready, 4'b0100);
    tick();
    #1;
    chk("sim_spent", bus.req_ready, 4'b0000);
    bus.req_valid = 4'b0000;
    repeat (12) tick();
    chk("drain_valid", bus.rsp_valid, 4'b0000);
    chk("drain_busy", busy, 1'b0);

    // Reset with five tags in flight
    bus.rsp_ready = 4'b0000;
    bus.req_valid = 4'b1111;
    repeat (5) tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("inflight_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.req_ready, 4'b0000);
    chk("mid_rst_valid", bus.rsp_valid, 4'b0000);
    chk("mid_rst_data", bus.rsp_data, 76'd0);
    chk("mid_rst_mul_n1", mul_n1, 11'd0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      chk("post_rst_stale", bus.rsp_valid, 4'b0000);
      tick();
    end
    chk("post_rst_busy", busy, 1'b0);
    bus.req_valid = 4'b0001;
    for (int c = 0; c < FIFO_DEPTH; c++) begin
      #1;
      chk("post_rst_credit", bus.req_ready, 4'b0001);
      tick();
    end
    #1;
    chk("post_rst_stall", bus.req_ready, 4'b0000);
    bus.req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
